// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master single-beat bus arbiter with bounded locking and read-data return
//
// Ports:
//   clk, reset (async, active-low)
//   m0_* / m1_*  : master request side (req, wr, addr, wdata, wmask, lock) and
//                  response side (gnt combinational, rvalid registered, rdata)
//   bus_*        : shared slave bus (addr, wdata, wmask, wr, rd strobes, rdata in)
//   LOCK_MAX     : longest run of locked cycles before a forced release (1..255)
//
// Configuration: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise master 0 has fixed priority.
module bus_arbiter #(
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_lock,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    output logic        bus_wr,
    output logic        bus_rd,
    input  logic [31:0] bus_rdata
);
    localparam logic [1:0] OPEN  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;
    localparam logic [7:0] LMAX  = 8'(LOCK_MAX);

    logic [1:0] state_q, state_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [1:0] starve_q, starve_d;
    logic [1:0] rvalid_q, rvalid_d;
    logic       open_st, pick1, held, expire, force_rel;
`ifdef ARB_ROUND_ROBIN_EN
    logic       last_q, last_d;
`endif

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = bus_rdata;
    assign m1_rdata  = bus_rdata;

    always_comb begin
        open_st = (state_q != LOCK0) && (state_q != LOCK1);
        // pick1: winner when both request in OPEN; a starved master overrides priority
`ifdef ARB_ROUND_ROBIN_EN
        pick1 = starve_q[1] | (~starve_q[0] & ~last_q);
`else
        pick1 = starve_q[1];
`endif
        m0_gnt = reset & m0_req & ((state_q == LOCK0) | (open_st & ~(m1_req & pick1)));
        m1_gnt = reset & m1_req & ((state_q == LOCK1) | (open_st & ~(m0_req & ~pick1)));
        held      = (state_q == LOCK0) ? m0_lock : m1_lock;
        expire    = lock_cnt_q == LMAX;
        force_rel = ~open_st & held & expire;
        state_d    = OPEN;
        lock_cnt_d = '0;
        if (open_st) begin
            if (m0_gnt & m0_lock) begin
                state_d    = LOCK0;
                lock_cnt_d = 8'd1;
            end else if (m1_gnt & m1_lock) begin
                state_d    = LOCK1;
                lock_cnt_d = 8'd1;
            end
        end else if (held & ~expire) begin
            state_d    = state_q;
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
        // starve[n] is raised when the other master's lock is cut off, and dropped
        // once master n is served or stops asking
        starve_d[0] = (force_rel & (state_q == LOCK1)) | (starve_q[0] & m0_req & ~m0_gnt);
        starve_d[1] = (force_rel & (state_q == LOCK0)) | (starve_q[1] & m1_req & ~m1_gnt);
        rvalid_d  = {m1_gnt & ~m1_wr, m0_gnt & ~m0_wr};
        bus_rd    = |rvalid_d;
        bus_wr    = (m0_gnt & m0_wr) | (m1_gnt & m1_wr);
        bus_addr  = m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
        bus_wdata = m1_gnt ? m1_wdata : m0_gnt ? m0_wdata : '0;
        bus_wmask = ~bus_wr ? '0 : m1_gnt ? m1_wmask : m0_wmask;
`ifdef ARB_ROUND_ROBIN_EN
        last_d = m0_gnt ? 1'b0 : m1_gnt ? 1'b1 : last_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= OPEN;
            lock_cnt_q <= '0;
            starve_q   <= '0;
            rvalid_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            starve_q   <= starve_d;
            rvalid_q   <= rvalid_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed table-driven bench for bus_arbiter
module tb_bus_arbiter;
    localparam int LM = 4;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m0_lock = 1'b0;
    logic        m1_req = 1'b0, m1_wr = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m1_wdata = '0, bus_rdata = '0;
    logic [31:0] m0_wdata = 32'h11;
    logic [3:0]  m0_wmask = 4'hF, m1_wmask = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_wr, bus_rd;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wmask;

    always #5 clk = ~clk;

    bus_arbiter #(.LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_lock(m0_lock),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        chk(n, {31'b0, act}, {31'b0, exp});
    endtask

    typedef struct {
        bit r0, w0, l0, r1, w1, l1;
        logic [31:0] a0, a1, d1;
        logic [3:0]  k1;
        logic [31:0] rd;
        bit g0, g1, brd, bwr, v0, v1;
        logic [31:0] ea, ed;
        logic [3:0]  em;
    } vec_t;

    vec_t v[12];

    task automatic apply(input vec_t x);
        m0_req = x.r0; m0_wr = x.w0; m0_lock = x.l0; m0_addr = x.a0;
        m1_req = x.r1; m1_wr = x.w1; m1_lock = x.l1; m1_addr = x.a1;
        m1_wdata = x.d1; m1_wmask = x.k1; bus_rdata = x.rd;
    endtask

    task automatic check(input string n, input vec_t x);
        chk1({n, ".m0_gnt"}, m0_gnt, x.g0);
        chk1({n, ".m1_gnt"}, m1_gnt, x.g1);
        chk1({n, ".bus_rd"}, bus_rd, x.brd);
        chk1({n, ".bus_wr"}, bus_wr, x.bwr);
        chk({n, ".bus_addr"}, bus_addr, x.ea);
        chk({n, ".bus_wdata"}, bus_wdata, x.ed);
        chk({n, ".bus_wmask"}, {28'b0, bus_wmask}, {28'b0, x.em});
        chk1({n, ".m0_rvalid"}, m0_rvalid, x.v0);
        chk1({n, ".m1_rvalid"}, m1_rvalid, x.v1);
        if (x.v0) chk({n, ".m0_rdata"}, m0_rdata, x.rd);
        if (x.v1) chk({n, ".m1_rdata"}, m1_rdata, x.rd);
    endtask

    initial begin
        bit g1b, pg1;
        v[0]  = '{L,L,L,L,L,L, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0,
                  L,L,L,L,L,L, 32'h0, 32'h0, 4'h0};
        v[1]  = '{H,L,L,L,L,L, 32'hf0000010, 32'h0, 32'h0, 4'h0, 32'h12345678,
                  H,L,H,L,L,L, 32'hf0000010, 32'h11, 4'h0};
        v[2]  = '{L,L,L,L,L,L, 32'h0, 32'h0, 32'h0, 4'h0, 32'h12345678,
                  L,L,L,L,H,L, 32'h0, 32'h0, 4'h0};
        v[3]  = '{L,L,L,H,H,L, 32'h0, 32'h10000000, 32'hA5, 4'h1, 32'h0,
                  L,H,L,H,L,L, 32'h10000000, 32'hA5, 4'h1};
        v[4]  = '{L,L,L,L,L,L, 32'h0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF,
                  L,L,L,L,L,L, 32'h0, 32'h0, 4'h0};
        pg1 = L;
        for (int i = 0; i < 6; i++) begin
            g1b = RR && (i % 2 == 1);
            v[5+i] = '{H,L,L,H,L,L, 32'h100, 32'h200, 32'h22, 4'h0, 32'hC0DE0000 + 32'(i),
                       !g1b, g1b, H, L, (i > 0) && !pg1, (i > 0) && pg1,
                       g1b ? 32'h200 : 32'h100, g1b ? 32'h22 : 32'h11, 4'h0};
            pg1 = g1b;
        end
        v[11] = '{L,L,L,L,L,L, 32'h0, 32'h0, 32'h0, 4'h0, 32'h5A5A5A5A,
                  L,L,L,L,!RR,RR, 32'h0, 32'h0, 4'h0};

        // reset held with both masters requesting: nothing may be granted
        m0_req = 1'b1; m1_req = 1'b1;
        #12;
        chk1("rst.m0_gnt", m0_gnt, 1'b0);
        chk1("rst.m1_gnt", m1_gnt, 1'b0);
        chk1("rst.bus_rd", bus_rd, 1'b0);
        chk("rst.bus_addr", bus_addr, 32'h0);
        chk1("rst.m0_rvalid", m0_rvalid, 1'b0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) reset = 1'b1;
            apply(v[i]);
            #1;
            check($sformatf("vec%0d", i), v[i]);
        end

        // m0 holds a lock and keeps requesting; m1 is forced in after the limit
        for (int c = 1; c <= LM + 3; c++) begin
            @(negedge clk);
            m0_req = 1'b1; m0_lock = 1'b1; m0_wr = 1'b0; m0_addr = 32'h300;
            m1_req = 1'b1; m1_lock = 1'b0; m1_wr = 1'b0; m1_addr = 32'h400;
            bus_rdata = 32'h0;
            #1;
            chk1($sformatf("lock%0d.m0_gnt", c), m0_gnt, c != LM + 2);
            chk1($sformatf("lock%0d.m1_gnt", c), m1_gnt, c == LM + 2);
        end
        // last cycle re-entered LOCK0; m1 must wait while the lock is held
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        chk1("hold.m1_gnt", m1_gnt, 1'b0);
        @(negedge clk);
        m0_lock = 1'b0;
        #1;
        chk1("unlock.m1_gnt", m1_gnt, 1'b0);
        @(negedge clk);
        #1;
        chk1("open.m1_gnt", m1_gnt, 1'b1);
        chk("open.bus_addr", bus_addr, 32'h400);
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        chk1("open.m1_rvalid", m1_rvalid, 1'b1);

        // m1 locked read, then reset lands before its data returns
        @(negedge clk);
        m1_req = 1'b1; m1_lock = 1'b1; m1_wr = 1'b0; m1_addr = 32'h500;
        #1;
        chk1("rr.m1_gnt", m1_gnt, 1'b1);
        chk1("rr.bus_rd", bus_rd, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m0_req = 1'b1;
        @(negedge clk);
        #1;
        chk1("rmid.m1_rvalid", m1_rvalid, 1'b0);
        chk1("rmid.m0_gnt", m0_gnt, 1'b0);
        chk1("rmid.m1_gnt", m1_gnt, 1'b0);
        chk1("rmid.bus_rd", bus_rd, 1'b0);
        chk1("rmid.bus_wr", bus_wr, 1'b0);
        chk("rmid.bus_addr", bus_addr, 32'h0);
        chk("rmid.bus_wdata", bus_wdata, 32'h0);
        chk("rmid.bus_wmask", {28'b0, bus_wmask}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        m1_req = 1'b0; m1_lock = 1'b0;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h600;
        #1;
        chk1("post.m0_gnt", m0_gnt, 1'b1);
        chk1("post.bus_wr", bus_wr, 1'b1);
        chk("post.bus_wmask", {28'b0, bus_wmask}, 32'hF);
        chk1("post.m1_rvalid", m1_rvalid, 1'b0);
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        chk1("post.m0_rvalid", m0_rvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
